swt16_loader: RTL and testbench

Boot/debug loader and the write-side counterpart of the swt16 core's read-only program-memory fetch and data-memory load paths. It accepts a framed byte stream over a valid/ready handshake and assembles 16-bit words. It writes those words into the PMEM or DMEM write port while holding the core in reset, then releases the core on command. It sits beside the core top level and drives the memory write ports and the core reset.

---
 rtl/swt16_loader.sv | 111 +++++++++++
 tb/tb_swt16_loader.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/swt16_loader.sv
// Boot/debug loader: framed byte stream -> 16-bit PMEM/DMEM writes, plus core reset control.
// Latency: write strobe in the cycle after the low data byte is accepted; one word per 3 cycles max.
// Backpressure: out_ready drops only during the single WRITE cycle; a held byte is taken right after.
module swt16_loader #(
    parameter int ADDR_WIDTH     = 12,
    parameter int WORD_WIDTH     = 16,
    parameter int ADDR_INCREMENT = 2
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  out_ready,
    output logic                  out_pmem_wr_en,
    output logic                  out_dmem_wr_en,
    output logic [ADDR_WIDTH-1:0] out_wr_addr,
    output logic [WORD_WIDTH-1:0] out_wr_word,
    output logic                  out_core_reset,
    output logic                  out_busy,
    output logic                  out_error
);

    localparam logic [7:0] CMD_PMEM = 8'h50;
    localparam logic [7:0] CMD_DMEM = 8'h44;
    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_HALT = 8'h48;

    typedef enum logic [3:0] {
        S_IDLE, S_LEN_HI, S_LEN_LO, S_ADDR_HI, S_ADDR_LO,
        S_DATA_HI, S_DATA_LO, S_WRITE, S_RUN
    } state_t;

    state_t                state, state_nxt;
    logic                  accept;
    logic                  is_dmem;
    logic [15:0]           count;
    logic [7:0]            hi_byte;
    logic [ADDR_WIDTH-1:0] addr;

    assign accept = in_valid & out_ready;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (accept) begin
                if (in_byte == CMD_PMEM || in_byte == CMD_DMEM) state_nxt = S_LEN_HI;
                else if (in_byte == CMD_GO)                     state_nxt = S_RUN;
            end
            S_LEN_HI:  if (accept) state_nxt = S_LEN_LO;
            S_LEN_LO:  if (accept) state_nxt = S_ADDR_HI;
            S_ADDR_HI: if (accept) state_nxt = S_ADDR_LO;
            S_ADDR_LO: if (accept) state_nxt = (count == 16'd0) ? S_IDLE : S_DATA_HI;
            S_DATA_HI: if (accept) state_nxt = S_DATA_LO;
            S_DATA_LO: if (accept) state_nxt = S_WRITE;
            S_WRITE:   state_nxt = (count == 16'd1) ? S_IDLE : S_DATA_HI;
            S_RUN:     if (accept && in_byte == CMD_HALT) state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // All outputs below depend on registered state only, never on the input byte.
    always_comb begin
        out_ready      = (state != S_WRITE);
        out_busy       = (state != S_IDLE) && (state != S_RUN);
        out_pmem_wr_en = (state == S_WRITE) && !is_dmem;
        out_dmem_wr_en = (state == S_WRITE) && is_dmem;
        out_core_reset = (state != S_RUN);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            is_dmem     <= 1'b0;
            count       <= '0;
            hi_byte     <= '0;
            addr        <= '0;
            out_wr_addr <= '0;
            out_wr_word <= '0;
            out_error   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    is_dmem <= (in_byte == CMD_DMEM);
                    if (in_byte != CMD_PMEM && in_byte != CMD_DMEM && in_byte != CMD_GO)
                        out_error <= 1'b1;
                end
                S_LEN_HI:  if (accept) count[15:8] <= in_byte;
                S_LEN_LO:  if (accept) count[7:0]  <= in_byte;
                S_ADDR_HI: if (accept) hi_byte     <= in_byte;
                // 16-bit address on the wire; only the low ADDR_WIDTH bits are kept.
                S_ADDR_LO: if (accept) addr        <= ADDR_WIDTH'({hi_byte, in_byte});
                S_DATA_HI: if (accept) hi_byte     <= in_byte;
                S_DATA_LO: if (accept) begin
                    out_wr_addr <= addr;
                    out_wr_word <= WORD_WIDTH'({hi_byte, in_byte});
                end
                S_WRITE: begin
                    addr  <= addr + ADDR_WIDTH'(ADDR_INCREMENT);
                    count <= count - 16'd1;
                end
                S_RUN: if (accept && in_byte != CMD_HALT) out_error <= 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_swt16_loader.sv
// Directed bench for swt16_loader: frames, wrap-around, zero-length, errors, async reset, run/halt.
module tb_swt16_loader;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  in_byte = 8'h00;
    logic        in_valid = 1'b0;
    logic        out_ready, out_pmem_wr_en, out_dmem_wr_en;
    logic [11:0] out_wr_addr;
    logic [15:0] out_wr_word;
    logic        out_core_reset, out_busy, out_error;

    int checks = 0;
    int errors = 0;
    int pmem_cnt = 0;
    int dmem_cnt = 0;

    swt16_loader #(.ADDR_WIDTH(12), .WORD_WIDTH(16), .ADDR_INCREMENT(2)) dut (
        .clock          (clock),
        .reset          (reset),
        .in_byte        (in_byte),
        .in_valid       (in_valid),
        .out_ready      (out_ready),
        .out_pmem_wr_en (out_pmem_wr_en),
        .out_dmem_wr_en (out_dmem_wr_en),
        .out_wr_addr    (out_wr_addr),
        .out_wr_word    (out_wr_word),
        .out_core_reset (out_core_reset),
        .out_busy       (out_busy),
        .out_error      (out_error)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (out_pmem_wr_en) pmem_cnt++;
        if (out_dmem_wr_en) dmem_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Presents one byte from just after a clock edge and holds it until it is taken.
    // Returns 1 time unit after the accepting edge.
    task automatic send(input logic [7:0] b);
        logic rdy;
        int   n;
        n = 0;
        in_byte  = b;
        in_valid = 1'b1;
        do begin
            rdy = out_ready;
            @(posedge clock);
            #1;
            n++;
        end while (!rdy && n < 10);
        in_valid = 1'b0;
        if (!rdy) begin
            checks++;
            errors++;
            $error("FAIL accept_timeout: byte %0h observed not accepted expected accepted", b);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_core_reset", 32'(out_core_reset), 1);
        chk("rst_ready",      32'(out_ready), 1);
        chk("rst_busy",       32'(out_busy), 0);
        chk("rst_error",      32'(out_error), 0);
        chk("rst_pmem_en",    32'(out_pmem_wr_en), 0);
        chk("rst_dmem_en",    32'(out_dmem_wr_en), 0);
        chk("rst_addr",       32'(out_wr_addr), 0);
        chk("rst_word",       32'(out_wr_word), 0);
        tick();
        reset = 1'b0;
        tick();

        // PMEM frame, two words
        send(8'h50);
        chk("p_busy_after_cmd", 32'(out_busy), 1);
        send(8'h00); send(8'h02); send(8'h00); send(8'h10);
        send(8'h12); send(8'h34);
        chk("p1_pmem_en", 32'(out_pmem_wr_en), 1);
        chk("p1_dmem_en", 32'(out_dmem_wr_en), 0);
        chk("p1_addr",    32'(out_wr_addr), 'h010);
        chk("p1_word",    32'(out_wr_word), 'h1234);
        chk("p1_ready",   32'(out_ready), 0);
        send(8'hAB); send(8'hCD);
        chk("p2_pmem_en", 32'(out_pmem_wr_en), 1);
        chk("p2_addr",    32'(out_wr_addr), 'h012);
        chk("p2_word",    32'(out_wr_word), 'hABCD);
        tick();
        chk("p_busy_done",  32'(out_busy), 0);
        chk("p_pmem_off",   32'(out_pmem_wr_en), 0);
        chk("p_addr_hold",  32'(out_wr_addr), 'h012);
        chk("p_word_hold",  32'(out_wr_word), 'hABCD);
        chk("p_pmem_count", 32'(pmem_cnt), 2);
        chk("p_dmem_count", 32'(dmem_cnt), 0);

        // DMEM single word at top of address space
        send(8'h44); send(8'h00); send(8'h01); send(8'h0F); send(8'hFE);
        send(8'h55); send(8'hAA);
        chk("d1_dmem_en", 32'(out_dmem_wr_en), 1);
        chk("d1_pmem_en", 32'(out_pmem_wr_en), 0);
        chk("d1_addr",    32'(out_wr_addr), 'hFFE);
        chk("d1_word",    32'(out_wr_word), 'h55AA);
        tick();

        // DMEM two words wrapping past the top
        send(8'h44); send(8'h00); send(8'h02); send(8'h0F); send(8'hFE);
        send(8'h11); send(8'h22);
        chk("dw1_addr", 32'(out_wr_addr), 'hFFE);
        chk("dw1_word", 32'(out_wr_word), 'h1122);
        send(8'h33); send(8'h44);
        chk("dw2_dmem_en", 32'(out_dmem_wr_en), 1);
        chk("dw2_addr",    32'(out_wr_addr), 'h000);
        chk("dw2_word",    32'(out_wr_word), 'h3344);
        tick();
        chk("dw_dmem_count", 32'(dmem_cnt), 3);

        // Zero-length PMEM frame, then release the core
        send(8'h50); send(8'h00); send(8'h00); send(8'h00); send(8'h20);
        chk("z_busy", 32'(out_busy), 0);
        tick(); tick();
        chk("z_pmem_count",   32'(pmem_cnt), 2);
        chk("z_core_held",    32'(out_core_reset), 1);
        send(8'h47);
        chk("g_core_release", 32'(out_core_reset), 0);
        chk("g_busy",         32'(out_busy), 0);

        // Halt from RUN
        send(8'h48);
        chk("h_core_reset", 32'(out_core_reset), 1);
        chk("h_error",      32'(out_error), 0);

        // Bad command in IDLE, then a valid frame at an odd address
        send(8'h99);
        chk("bad_error", 32'(out_error), 1);
        chk("bad_busy",  32'(out_busy), 0);
        send(8'h50); send(8'h00); send(8'h01); send(8'h01); send(8'h23);
        send(8'hBE); send(8'hEF);
        chk("odd_pmem_en", 32'(out_pmem_wr_en), 1);
        chk("odd_addr",    32'(out_wr_addr), 'h123);
        chk("odd_word",    32'(out_wr_word), 'hBEEF);
        tick();
        chk("bad_error_sticky", 32'(out_error), 1);

        // Async reset after the high data byte
        send(8'h50); send(8'h00); send(8'h02); send(8'h00); send(8'h40);
        send(8'h77);
        #2 reset = 1'b1;
        #1;
        chk("mr_busy",  32'(out_busy), 0);
        chk("mr_error", 32'(out_error), 0);
        chk("mr_addr",  32'(out_wr_addr), 0);
        tick(); tick();
        reset = 1'b0;
        tick();
        chk("mr_pmem_count", 32'(pmem_cnt), 3);
        send(8'h44); send(8'h00); send(8'h01); send(8'h00); send(8'h08);
        send(8'hCA); send(8'hFE);
        chk("fr_dmem_en", 32'(out_dmem_wr_en), 1);
        chk("fr_addr",    32'(out_wr_addr), 'h008);
        chk("fr_word",    32'(out_wr_word), 'hCAFE);
        tick();

        // Unknown byte in RUN, then async reset while running
        send(8'h47);
        chk("run_core", 32'(out_core_reset), 0);
        send(8'h13);
        chk("run_bad_error", 32'(out_error), 1);
        chk("run_bad_stay",  32'(out_core_reset), 0);
        #2 reset = 1'b1;
        #1;
        chk("run_rst_core",  32'(out_core_reset), 1);
        chk("run_rst_error", 32'(out_error), 0);
        tick();
        reset = 1'b0;
        tick();

        // Reload and release again
        send(8'h50); send(8'h00); send(8'h01); send(8'h00); send(8'h00);
        send(8'h12); send(8'h34);
        chk("rl_pmem_en", 32'(out_pmem_wr_en), 1);
        chk("rl_addr",    32'(out_wr_addr), 'h000);
        chk("rl_word",    32'(out_wr_word), 'h1234);
        tick();
        send(8'h47);
        chk("rl_core_release", 32'(out_core_reset), 0);
        chk("final_pmem_count", 32'(pmem_cnt), 4);
        chk("final_dmem_count", 32'(dmem_cnt), 4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
